// File: rtl/uart_text_console_if.sv
// Byte input, character read port and cursor/status outputs of the text console.
// Purely structural: carries no state and adds no latency.
// No backpressure: byteReady is a one-cycle strobe; the console buffers or drops bytes internally.
interface uart_text_console_if #(
    parameter int COLS = 16,
    parameter int ROWS = 4
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic             byteReady;
    logic [7:0]       dataIn;
    logic [RW+CW-1:0] charAddress;
    logic [7:0]       charOutput;
    logic [RW-1:0]    cursorRow;
    logic [CW-1:0]    cursorCol;
    logic             busy;
    logic             overflow;

    // Console side
    modport slave (
        input  byteReady, dataIn, charAddress,
        output charOutput, cursorRow, cursorCol, busy, overflow
    );

    // Byte source / text engine side
    modport master (
        output byteReady, dataIn, charAddress,
        input  charOutput, cursorRow, cursorCol, busy, overflow
    );
endinterface

// File: rtl/uart_text_console.sv
// Scrolling character console: turns a received byte stream into a ROWS x COLS text buffer.
// One cycle per byte in IDLE; charOutput is registered one cycle after charAddress.
// While a clear runs, one byte is parked in a pending register; a further byte is dropped and flagged.
module uart_text_console #(
    parameter int         COLS  = 16,
    parameter int         ROWS  = 4,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic               clk,
    input  logic               rst,
    uart_text_console_if.slave bus
);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int AW    = CW + RW;
    localparam int CELLS = ROWS * COLS;

    localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);

    typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] top_row, top_nxt;
    logic [RW-1:0] cur_row, row_nxt;
    logic [CW-1:0] cur_col, col_nxt;
    logic [AW-1:0] clr_cnt, cnt_nxt;
    logic          pend_vld, pend_vld_nxt;
    logic [7:0]    pend_dat, pend_dat_nxt;
    logic          ovf, ovf_nxt;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_dat;

    logic          consume;
    logic          in_vld;
    logic [7:0]    in_dat;
    logic          newline;

    logic [RW-1:0] cur_phys;
    logic [RW-1:0] clr_phys;
    logic [RW-1:0] rd_phys;

    logic [7:0]    mem [CELLS];
    logic [7:0]    char_q;

    // Visual rows map onto physical rows through the scroll pointer; row writes
    // never move, scrolling only rotates top_row.
    assign cur_phys = cur_row + top_row;
    assign clr_phys = LAST_ROW + top_row;
    assign rd_phys  = bus.charAddress[AW-1:CW] + top_row;

    // Next-state logic: clear sequencing, byte interpretation and pending-slot management
    always_comb begin
        state_nxt    = state;
        top_nxt      = top_row;
        row_nxt      = cur_row;
        col_nxt      = cur_col;
        cnt_nxt      = clr_cnt;
        pend_vld_nxt = pend_vld;
        pend_dat_nxt = pend_dat;
        ovf_nxt      = ovf;
        wr_en        = 1'b0;
        wr_addr      = clr_cnt;
        wr_dat       = BLANK;
        newline      = 1'b0;
        // The pending byte always has priority over a fresh strobe in IDLE.
        consume      = (state == IDLE) && pend_vld;
        in_vld       = consume || ((state == IDLE) && bus.byteReady);
        in_dat       = pend_vld ? pend_dat : bus.dataIn;

        case (state)
            CLEAR_ALL: begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt;
                cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == LAST_CELL) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            CLEAR_ROW: begin
                wr_en   = 1'b1;
                wr_addr = {clr_phys, clr_cnt[CW-1:0]};
                cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt[CW-1:0] == LAST_COL) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                if (in_vld) begin
                    if (in_dat >= 8'h20 && in_dat <= 8'h7e) begin
                        wr_en   = 1'b1;
                        wr_addr = {cur_phys, cur_col};
                        wr_dat  = in_dat;
                        if (cur_col != LAST_COL) begin
                            col_nxt = cur_col + 1'b1;
                        end else begin
                            newline = 1'b1;
                        end
                    end else if (in_dat == 8'h0a) begin
                        newline = 1'b1;
                    end else if (in_dat == 8'h0d) begin
                        col_nxt = '0;
                    end else if (in_dat == 8'h08 && cur_col != '0) begin
                        col_nxt = cur_col - 1'b1;
                        wr_en   = 1'b1;
                        wr_addr = {cur_phys, col_nxt};
                    end
                    if (newline) begin
                        col_nxt = '0;
                        if (cur_row != LAST_ROW) begin
                            row_nxt = cur_row + 1'b1;
                        end else begin
                            // The old top row becomes the new bottom row and must be blanked.
                            top_nxt   = top_row + 1'b1;
                            state_nxt = CLEAR_ROW;
                            cnt_nxt   = '0;
                        end
                    end
                end
            end
        endcase

        if (consume) begin
            pend_vld_nxt = 1'b0;
        end
        // A strobe not taken directly goes to the pending slot if it is (or is becoming) free.
        if (bus.byteReady && !((state == IDLE) && !pend_vld)) begin
            if (pend_vld && !consume) begin
                ovf_nxt = 1'b1;
            end else begin
                pend_vld_nxt = 1'b1;
                pend_dat_nxt = bus.dataIn;
            end
        end
    end

    // State register; reset restarts the full-screen clear from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR_ALL;
            top_row  <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
            clr_cnt  <= '0;
            pend_vld <= 1'b0;
            pend_dat <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nxt;
            top_row  <= top_nxt;
            cur_row  <= row_nxt;
            cur_col  <= col_nxt;
            clr_cnt  <= cnt_nxt;
            pend_vld <= pend_vld_nxt;
            pend_dat <= pend_dat_nxt;
            ovf      <= ovf_nxt;
        end
    end

    // Character store write port; writes are suppressed while reset is held
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Registered read port; a same-cycle write to the addressed cell returns the old value
    always_ff @(posedge clk) begin
        if (rst) begin
            char_q <= BLANK;
        end else begin
            char_q <= mem[{rd_phys, bus.charAddress[CW-1:0]}];
        end
    end

    assign bus.charOutput = char_q;
    assign bus.cursorRow  = cur_row;
    assign bus.cursorCol  = cur_col;
    assign bus.busy       = (state != IDLE);
    assign bus.overflow   = ovf;
endmodule
